fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front-end instruction fetch stage; the receiving end of the fetch control interface (pc_override, target) driven by the hazard controller.
- Holds the architectural fetch PC and issues sequential requests to a synchronous 1-cycle instruction memory.
- Buffers returned instructions in a 2-entry queue and presents them to the i2d pipeline register with a valid/ready handshake.
- On pc_override, flushes in-flight and buffered instructions and redirects to the supplied target.

Parameters:
- PC_SIZE, 16, width of PC and instruction-memory address (matches `PC_SIZE).
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ctrl_pc_override  in  1  redirect request from hazard controller (fetch_ctrl_ifc.pc_override)
- ctrl_target  in  PC_SIZE  redirect address (fetch_ctrl_ifc.target)
- imem_req  out  1  instruction memory read enable this cycle
- imem_addr  out  PC_SIZE  read address; equals the PC register
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_req
- out_valid  out  1  head of buffer valid
- out_pc  out  PC_SIZE  PC of head instruction
- out_instr  out  INSTR_WIDTH  head instruction
- out_ready  in  1  downstream accepts head; pop = out_valid & out_ready

Behaviour:
- Reset (rst=1 at an edge): pc <= RESET_PC; buffer count <= 0; in-flight flag <= 0. rst overrides all other inputs, including ctrl_pc_override.
- Outputs while rst=1: imem_req=0, out_valid=0.
- Outputs: out_valid/out_pc/out_instr come from the buffer head; out_valid = (count != 0) & ~ctrl_pc_override. imem_addr = pc always.
- Issue rule: imem_req = ~rst & ~ctrl_pc_override & (count + inflight - pop < 2).
  - This credit scheme guarantees the buffer never overflows.
  - On issue: pc <= pc + 1 modulo 2^PC_SIZE (0xFFFF wraps to 0x0000); inflight <= 1, tagged with the issued pc.
  - No issue: pc holds; inflight <= 0.
- Return: when inflight=1 at the start of a cycle, that cycle's {inflight_pc, imem_rdata} is written to the buffer tail at the edge.
- Buffer update: same-cycle pop and push allowed; count updates by push - pop.
- Latency: request issued in cycle n -> out_valid in cycle n+2. Steady state with out_ready=1 gives one instruction per cycle.
- Override (ctrl_pc_override=1 in cycle t):
  - out_valid forced 0 in t; no pop occurs.
  - imem_req=0 in t.
  - At the edge: buffer cleared; inflight cleared, so the response arriving in t is dropped; pc <= ctrl_target.
  - t+1: request for target. t+3: out_valid with out_pc=target.
- Back-to-back overrides: the last one wins; each one flushes.
- Override while out_ready=0 or buffer full: identical flush behaviour.
- Backpressure: out_ready=0 holds the head stable (out_pc/out_instr unchanged while out_valid=1). Issue stops once count + inflight = 2.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, imem returns addr^0xA5A5: imem_addr 0,1,2 in cycles 0,1,2; out_valid first in cycle 2 with out_pc=0, then pc 1,2 on consecutive cycles.
- out_ready=0 from cycle 2 for 5 cycles:
  - imem_req drops after 2 outstanding (count=2).
  - Head stays at pc 0.
  - On out_ready=1, pcs 0,1,2 appear in order with none lost or duplicated.
- Override in cycle 6 with target=0x0040 and the buffer holding 2 entries:
  - out_valid=0 in cycle 6.
  - imem_addr=0x0040 with imem_req=1 in cycle 7.
  - out_pc=0x0040 in cycle 9; no pre-override pc appears after cycle 5.
- Override in consecutive cycles with targets 0x10 then 0x20: only 0x20 is fetched; first output is out_pc=0x20.
- ctrl_target=0xFFFF: outputs 0xFFFF then 0x0000 (wrap).
- rst=1 together with ctrl_pc_override=1, target=0x55: after release, fetch restarts at RESET_PC and 0x55 is never requested.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: front-end instruction fetch stage.
//
// Holds the fetch PC and issues sequential reads to a synchronous
// instruction memory with a one-cycle read latency. Returned words go into
// a two-entry queue. The queue head is offered downstream with a
// valid/ready handshake. A redirect from the hazard controller flushes the
// queue and any in-flight read, then restarts fetch at the supplied target.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ctrl_pc_override  redirect request (flushes and reloads the PC)
//   ctrl_target       redirect address
//   imem_req          read enable this cycle
//   imem_addr         read address, always the PC register
//   imem_rdata        read data, valid the cycle after imem_req
//   out_valid         queue head is valid
//   out_pc            PC of the queue head
//   out_instr         instruction at the queue head
//   out_ready         downstream accepts the head this cycle
module fetch_unit #(
  parameter int PC_SIZE = 16,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_pc_override,
  input  logic [PC_SIZE-1:0]     ctrl_target,
  output logic                   imem_req,
  output logic [PC_SIZE-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  output logic [PC_SIZE-1:0]     out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   out_ready
);

  logic [PC_SIZE-1:0]     pc;
  logic                   inflight;
  logic [PC_SIZE-1:0]     inflight_pc;
  logic [1:0]             count;

  logic [PC_SIZE-1:0]     head_pc, tail_pc;
  logic [INSTR_WIDTH-1:0] head_instr, tail_instr;

  logic                   pop, push;
  logic [2:0]             occupancy, limit;
  logic [1:0]             remaining;
  logic [1:0]             n_count;
  logic [PC_SIZE-1:0]     n_head_pc, n_tail_pc;
  logic [INSTR_WIDTH-1:0] n_head_instr, n_tail_instr;

  assign out_valid = (count != 2'd0) & ~ctrl_pc_override & ~rst;
  assign out_pc    = head_pc;
  assign out_instr = head_instr;
  assign imem_addr = pc;
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~ctrl_pc_override;

  // Credit check: entries held plus the read in flight, minus the one
  // leaving this cycle, must stay below two so a returning word always
  // has a free slot. Written as occupancy < 2 + pop to avoid underflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  assign limit     = 3'd2 + {2'b00, pop};
  assign imem_req  = ~rst & ~ctrl_pc_override & (occupancy < limit);

  // Queue next-state: a pop shifts the tail into the head; a push lands in
  // the first free slot after that pop.
  always_comb begin
    n_head_pc    = head_pc;
    n_head_instr = head_instr;
    n_tail_pc    = tail_pc;
    n_tail_instr = tail_instr;
    remaining    = count - {1'b0, pop};
    if (pop) begin
      n_head_pc    = tail_pc;
      n_head_instr = tail_instr;
    end
    if (push) begin
      if (remaining == 2'd0) begin
        n_head_pc    = inflight_pc;
        n_head_instr = imem_rdata;
      end else begin
        n_tail_pc    = inflight_pc;
        n_tail_instr = imem_rdata;
      end
    end
    n_count = remaining + {1'b0, push};
  end

  // Control state. A redirect empties the queue and drops the read in
  // flight, so the word returning during the redirect cycle is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (ctrl_pc_override) begin
      pc       <= ctrl_target;
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      count <= n_count;
      if (imem_req) begin
        pc          <= pc + {{(PC_SIZE-1){1'b0}}, 1'b1};
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // Queue payload needs no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    head_pc    <= n_head_pc;
    head_instr <= n_head_instr;
    tail_pc    <= n_tail_pc;
    tail_instr <= n_tail_instr;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
//
// A small instruction memory model answers every read one cycle later with
// addr ^ 16'hA5A5. Each call to applyStimulus moves to the next cycle and
// drives that cycle's inputs. Outputs are checked shortly afterwards,
// well away from the clock edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        ctrl_pc_override;
  logic [15:0] ctrl_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic        out_ready;

  int total;
  int bad;

  fetch_unit #(
    .PC_SIZE(16),
    .INSTR_WIDTH(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_pc_override(ctrl_pc_override),
    .ctrl_target(ctrl_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready)
  );

  // Free-running clock with a 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the request
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 16'hA5A5;
  end

  // Advance one cycle, then drive that cycle's inputs
  task automatic applyStimulus(input logic r, input logic ovr,
                               input logic [15:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    rst              = r;
    ctrl_pc_override = ovr;
    ctrl_target      = tgt;
    out_ready        = rdy;
    #1;
  endtask

  // Count one comparison and report it when the values differ
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bound the whole run in case something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; ctrl_pc_override = 1'b0; ctrl_target = 16'h0; out_ready = 1'b1;
    imem_rdata = 16'h0;

    // Reset and sequential fetch with out_ready held high
    applyStimulus(1, 0, 16'h0, 1);
    applyStimulus(1, 0, 16'h0, 1);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("c0_req", imem_req, 1);
    checkOutput("c0_addr", imem_addr, 16'h0000);
    checkOutput("c0_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("c1_addr", imem_addr, 16'h0001);
    checkOutput("c1_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("c2_addr", imem_addr, 16'h0002);
    checkOutput("c2_valid", out_valid, 1);
    checkOutput("c2_pc", out_pc, 16'h0000);
    checkOutput("c2_instr", out_instr, 16'hA5A5);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("c3_pc", out_pc, 16'h0001);
    checkOutput("c3_instr", out_instr, 16'hA5A4);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("c4_valid", out_valid, 1);
    checkOutput("c4_pc", out_pc, 16'h0002);

    // Backpressure for cycles 2..6: issue stops at two outstanding, head holds
    applyStimulus(1, 0, 16'h0, 1);
    applyStimulus(0, 0, 16'h0, 1);
    applyStimulus(0, 0, 16'h0, 1);
    for (int c = 2; c <= 6; c++) begin
      applyStimulus(0, 0, 16'h0, 0);
      checkOutput("bp_req", imem_req, 0);
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_head_pc", out_pc, 16'h0000);
    end
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bp_c7_pc", out_pc, 16'h0000);
    checkOutput("bp_c7_req", imem_req, 1);
    checkOutput("bp_c7_addr", imem_addr, 16'h0002);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bp_c8_pc", out_pc, 16'h0001);
    checkOutput("bp_c8_instr", out_instr, 16'hA5A4);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bp_c9_valid", out_valid, 1);
    checkOutput("bp_c9_pc", out_pc, 16'h0002);

    // Redirect in cycle 6 while the queue is full
    applyStimulus(1, 0, 16'h0, 1);
    applyStimulus(0, 0, 16'h0, 1);
    applyStimulus(0, 0, 16'h0, 1);
    for (int c = 2; c <= 5; c++) applyStimulus(0, 0, 16'h0, 0);
    checkOutput("ov_c5_valid", out_valid, 1);
    applyStimulus(0, 1, 16'h0040, 0);
    checkOutput("ov_c6_valid", out_valid, 0);
    checkOutput("ov_c6_req", imem_req, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("ov_c7_req", imem_req, 1);
    checkOutput("ov_c7_addr", imem_addr, 16'h0040);
    checkOutput("ov_c7_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("ov_c8_valid", out_valid, 0);
    checkOutput("ov_c8_addr", imem_addr, 16'h0041);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("ov_c9_valid", out_valid, 1);
    checkOutput("ov_c9_pc", out_pc, 16'h0040);
    checkOutput("ov_c9_instr", out_instr, 16'hA5E5);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("ov_c10_pc", out_pc, 16'h0041);
    checkOutput("ov_c10_instr", out_instr, 16'hA5E4);

    // Back-to-back redirects: the later target wins
    applyStimulus(0, 1, 16'h0010, 1);
    checkOutput("bb_a_req", imem_req, 0);
    applyStimulus(0, 1, 16'h0020, 1);
    checkOutput("bb_b_req", imem_req, 0);
    checkOutput("bb_b_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bb_c_addr", imem_addr, 16'h0020);
    checkOutput("bb_c_req", imem_req, 1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bb_d_valid", out_valid, 0);
    checkOutput("bb_d_addr", imem_addr, 16'h0021);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("bb_e_valid", out_valid, 1);
    checkOutput("bb_e_pc", out_pc, 16'h0020);
    checkOutput("bb_e_instr", out_instr, 16'hA585);

    // Redirect to the top of the address space, then wrap to zero
    applyStimulus(0, 1, 16'hFFFF, 1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("wr_a_addr", imem_addr, 16'hFFFF);
    checkOutput("wr_a_req", imem_req, 1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("wr_b_addr", imem_addr, 16'h0000);
    checkOutput("wr_b_req", imem_req, 1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("wr_c_pc", out_pc, 16'hFFFF);
    checkOutput("wr_c_instr", out_instr, 16'h5A5A);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("wr_d_valid", out_valid, 1);
    checkOutput("wr_d_pc", out_pc, 16'h0000);
    checkOutput("wr_d_instr", out_instr, 16'hA5A5);

    // Reset coinciding with a redirect: reset wins
    applyStimulus(1, 1, 16'h0055, 1);
    checkOutput("rr_req", imem_req, 0);
    checkOutput("rr_valid", out_valid, 0);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("rr_c0_addr", imem_addr, 16'h0000);
    checkOutput("rr_c0_req", imem_req, 1);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("rr_c1_addr", imem_addr, 16'h0001);
    applyStimulus(0, 0, 16'h0, 1);
    checkOutput("rr_c2_valid", out_valid, 1);
    checkOutput("rr_c2_pc", out_pc, 16'h0000);
    checkOutput("rr_c2_addr", imem_addr, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
